// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the instruction fetch unit
// (read-only) and the load/store unit (read/write). One transaction is in
// flight at a time, ties are broken round-robin, and a watchdog turns a
// memory that never completes into an error response.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last cycle before the watchdog response is due.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_t;

  state_t           state;
  owner_t           owner;
  owner_t           last_owner;
  logic [CNT_W-1:0] wd_cnt;

  logic grant_ifu;
  logic grant_lsu;
  logic timeout_hit;
  logic done_ok;
  logic done_err;

  // Combinational grant in IDLE; the master that did not go last wins a tie.
  // Gated by reset so no ready is presented while the block is held in reset.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (rst && state == IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (last_owner == OWN_LSU) grant_ifu = 1'b1;
        else                       grant_lsu = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // Completion decode: a memory response in WAIT beats a coinciding timeout.
  always_comb begin
    timeout_hit = (TIMEOUT != 0) && (wd_cnt == LAST_CNT);
    done_ok     = (state == WAIT) && mem_resp_valid;
    done_err    = (state == REQ || state == WAIT) && timeout_hit && !done_ok;
  end

  // Transaction FSM with registered memory-side latches and response pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      owner          <= OWN_IFU;
      last_owner     <= OWN_LSU;
      wd_cnt         <= '0;
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_addr       <= '0;
      mem_wen        <= 1'b0;
      mem_wdata      <= '0;
      mem_wmask      <= '0;
    end else begin
      ifu_resp_valid <= 1'b0;
      lsu_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ifu || grant_lsu) begin
            if (grant_lsu) begin
              owner      <= OWN_LSU;
              last_owner <= OWN_LSU;
              mem_addr   <= lsu_addr;
              mem_wen    <= lsu_wen;
              mem_wdata  <= lsu_wdata;
              mem_wmask  <= lsu_wmask;
            end else begin
              owner      <= OWN_IFU;
              last_owner <= OWN_IFU;
              mem_addr   <= ifu_addr;
              mem_wen    <= 1'b0;
              mem_wdata  <= '0;
              mem_wmask  <= '0;
            end
            wd_cnt        <= '0;
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (!done_err && mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (done_ok || done_err) begin
        resp_rdata    <= done_ok ? mem_rdata : '0;
        resp_err      <= done_err;
        mem_req_valid <= 1'b0;
        state         <= IDLE;
        if (owner == OWN_LSU) lsu_resp_valid <= 1'b1;
        else                  ifu_resp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand-written corner
// sequences and a randomized run, all checked against a cycle-number based
// transaction model.
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_addr(ifu_addr), .ifu_resp_valid(ifu_resp_valid),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata),
    .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_resp_valid(mem_resp_valid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- transaction model (absolute cycle numbers) ----------------
  int          cyc = 0;
  bit          m_busy, m_hs, m_own_lsu, m_last_lsu, m_resp_lsu;
  int          m_entry, m_resp_cyc;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_wen, m_err;
  logic [3:0]  m_wmask;
  bit          exp_ifu_acc, exp_lsu_acc;

  task automatic model_reset();
    m_busy = 0; m_hs = 0; m_own_lsu = 0; m_last_lsu = 1; m_resp_lsu = 0;
    m_entry = 0; m_resp_cyc = -1;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_wen = 0; m_err = 0; m_wmask = '0;
    exp_ifu_acc = 0; exp_lsu_acc = 0;
  endtask

  task automatic model_respond(input bit ok);
    m_resp_cyc = cyc + 1;
    m_resp_lsu = m_own_lsu;
    m_rdata    = ok ? mem_rdata : 32'h0;
    m_err      = !ok;
    m_busy     = 0;
  endtask

  // Check DUT outputs of the current cycle, then advance the model by one cycle.
  task automatic model_step();
    bit g_ifu, g_lsu, e_mreq, e_irv, e_lrv;
    g_ifu = 0; g_lsu = 0;
    if (!m_busy) begin
      if (ifu_req_valid && lsu_req_valid) begin
        g_ifu = m_last_lsu;
        g_lsu = !m_last_lsu;
      end else begin
        g_ifu = ifu_req_valid;
        g_lsu = lsu_req_valid;
      end
    end
    e_mreq = m_busy && !m_hs;
    e_irv  = (m_resp_cyc == cyc) && !m_resp_lsu;
    e_lrv  = (m_resp_cyc == cyc) && m_resp_lsu;
    chk($sformatf("model c%0d ifu_req_ready", cyc), 64'(ifu_req_ready), 64'(g_ifu));
    chk($sformatf("model c%0d lsu_req_ready", cyc), 64'(lsu_req_ready), 64'(g_lsu));
    chk($sformatf("model c%0d mem_req_valid", cyc), 64'(mem_req_valid), 64'(e_mreq));
    chk($sformatf("model c%0d ifu_resp_valid", cyc), 64'(ifu_resp_valid), 64'(e_irv));
    chk($sformatf("model c%0d lsu_resp_valid", cyc), 64'(lsu_resp_valid), 64'(e_lrv));
    if (e_mreq) begin
      chk($sformatf("model c%0d mem_addr", cyc), 64'(mem_addr), 64'(m_addr));
      chk($sformatf("model c%0d mem_wen", cyc), 64'(mem_wen), 64'(m_wen));
      chk($sformatf("model c%0d mem_wdata", cyc), 64'(mem_wdata), 64'(m_wdata));
      chk($sformatf("model c%0d mem_wmask", cyc), 64'(mem_wmask), 64'(m_wmask));
    end
    if (e_irv || e_lrv) begin
      chk($sformatf("model c%0d resp_rdata", cyc), 64'(resp_rdata), 64'(m_rdata));
      chk($sformatf("model c%0d resp_err", cyc), 64'(resp_err), 64'(m_err));
    end
    exp_ifu_acc = g_ifu;
    exp_lsu_acc = g_lsu;
    if (!m_busy) begin
      if (g_ifu || g_lsu) begin
        m_busy     = 1;
        m_hs       = 0;
        m_entry    = cyc + 1;
        m_own_lsu  = g_lsu;
        m_last_lsu = g_lsu;
        m_addr     = g_lsu ? lsu_addr : ifu_addr;
        m_wen      = g_lsu ? lsu_wen : 1'b0;
        m_wdata    = g_lsu ? lsu_wdata : 32'h0;
        m_wmask    = g_lsu ? lsu_wmask : 4'h0;
      end
    end else if (!m_hs) begin
      if (TO != 0 && cyc + 1 == m_entry + TO) model_respond(0);
      else if (mem_req_ready) m_hs = 1;
    end else begin
      if (mem_resp_valid) model_respond(1);
      else if (TO != 0 && cyc + 1 == m_entry + TO) model_respond(0);
    end
    cyc++;
  endtask

  task automatic settle();
    #1;
    model_step();
  endtask

  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " ifu_req_ready"}, 64'(ifu_req_ready), 64'h0);
    chk({tag, " lsu_req_ready"}, 64'(lsu_req_ready), 64'h0);
    chk({tag, " ifu_resp_valid"}, 64'(ifu_resp_valid), 64'h0);
    chk({tag, " lsu_resp_valid"}, 64'(lsu_resp_valid), 64'h0);
    chk({tag, " resp_rdata"}, 64'(resp_rdata), 64'h0);
    chk({tag, " resp_err"}, 64'(resp_err), 64'h0);
    chk({tag, " mem_req_valid"}, 64'(mem_req_valid), 64'h0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'h0);
    chk({tag, " mem_wen"}, 64'(mem_wen), 64'h0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'h0);
    chk({tag, " mem_wmask"}, 64'(mem_wmask), 64'h0);
  endtask

  // Drop requests and let any transaction finish; bounded.
  task automatic drain();
    bit done = 0;
    ifu_req_valid = 0; lsu_req_valid = 0;
    mem_req_ready = 1; mem_resp_valid = 1;
    for (int i = 0; i < 30 && !done; i++) begin
      settle();
      next_cyc();
      done = !m_busy && (m_resp_cyc < cyc);
    end
    chk("drain completes", 64'(done), 64'h1);
    mem_resp_valid = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iv; logic [31:0] ia; logic lv; logic [31:0] la; logic lw;
    logic [31:0] ld; logic [3:0] lm; logic mr; logic mv; logic [31:0] md;
    logic ir; logic lr; logic mq; logic [31:0] ma; logic mw; logic [31:0] mdat;
    logic [3:0] mm; logic irv; logic lrv; logic [31:0] rd; logic re;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int grants[$];
    int got;

    // Fields: iv ia lv la lw ld lm mr mv md | ir lr mq ma mw mdat mm irv lrv rd re
    vecs[0] = '{1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0010_0073,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0010_0073, 1'b0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[5] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h1234_5678,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0};
    vecs[7] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0,
                1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0};

    rst = 0;
    ifu_req_valid = 0; ifu_addr = '0;
    lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    model_reset();
    #1;
    check_zero("reset");
    next_cyc();
    next_cyc();
    rst = 1;

    // IFU read then LSU write, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      ifu_req_valid = vecs[i].iv; ifu_addr = vecs[i].ia;
      lsu_req_valid = vecs[i].lv; lsu_addr = vecs[i].la; lsu_wen = vecs[i].lw;
      lsu_wdata = vecs[i].ld; lsu_wmask = vecs[i].lm;
      mem_req_ready = vecs[i].mr; mem_resp_valid = vecs[i].mv; mem_rdata = vecs[i].md;
      settle();
      chk($sformatf("vec%0d ifu_req_ready", i), 64'(ifu_req_ready), 64'(vecs[i].ir));
      chk($sformatf("vec%0d lsu_req_ready", i), 64'(lsu_req_ready), 64'(vecs[i].lr));
      chk($sformatf("vec%0d mem_req_valid", i), 64'(mem_req_valid), 64'(vecs[i].mq));
      chk($sformatf("vec%0d ifu_resp_valid", i), 64'(ifu_resp_valid), 64'(vecs[i].irv));
      chk($sformatf("vec%0d lsu_resp_valid", i), 64'(lsu_resp_valid), 64'(vecs[i].lrv));
      if (vecs[i].mq) begin
        chk($sformatf("vec%0d mem_addr", i), 64'(mem_addr), 64'(vecs[i].ma));
        chk($sformatf("vec%0d mem_wen", i), 64'(mem_wen), 64'(vecs[i].mw));
        chk($sformatf("vec%0d mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].mdat));
        chk($sformatf("vec%0d mem_wmask", i), 64'(mem_wmask), 64'(vecs[i].mm));
      end
      if (vecs[i].irv || vecs[i].lrv) begin
        chk($sformatf("vec%0d resp_rdata", i), 64'(resp_rdata), 64'(vecs[i].rd));
        chk($sformatf("vec%0d resp_err", i), 64'(resp_err), 64'(vecs[i].re));
      end
      next_cyc();
    end

    // Both masters valid from reset: alternating single-cycle grants
    rst = 0;
    model_reset();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0;
    mem_req_ready = 1; mem_resp_valid = 1; mem_rdata = 32'h0BAD_CAFE;
    #1;
    check_zero("reset with requests");
    next_cyc();
    rst = 1;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("tie both ready", 64'(ifu_req_ready && lsu_req_ready), 64'h0);
      if (ifu_req_ready) grants.push_back(0);
      if (lsu_req_ready) grants.push_back(1);
      next_cyc();
    end
    chk("tie grant count >= 4", 64'(grants.size() >= 4), 64'h1);
    for (int i = 0; i < 4; i++)
      chk($sformatf("tie grant %0d owner", i), 64'((i < grants.size()) ? grants[i] : 9), 64'(i % 2));
    drain();

    // Reset while in WAIT abandons the transaction
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1; mem_resp_valid = 0;
    settle(); next_cyc();
    lsu_req_valid = 0;
    settle(); next_cyc();
    settle();
    rst = 0;
    model_reset();
    ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1;
    #1;
    check_zero("reset in wait");
    next_cyc();
    #1;
    check_zero("held in reset");
    next_cyc();
    rst = 1;
    mem_resp_valid = 0;
    settle();
    chk("post-reset tie grants ifu", 64'(ifu_req_ready), 64'h1);
    next_cyc();
    ifu_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      settle(); next_cyc();
    end
    drain();

    // Memory stalls 5 cycles while IFU raises a request
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 1;
    lsu_wdata = 32'h55AA_55AA; lsu_wmask = 4'h3;
    mem_req_ready = 0; mem_resp_valid = 0;
    settle(); next_cyc();
    lsu_req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i >= 1) begin ifu_req_valid = 1; ifu_addr = 32'h8000_0040; end
      settle();
      chk($sformatf("stall%0d mem_req_valid", i), 64'(mem_req_valid), 64'h1);
      chk($sformatf("stall%0d mem_addr", i), 64'(mem_addr), 64'h8000_3000);
      chk($sformatf("stall%0d mem_wdata", i), 64'(mem_wdata), 64'h55AA_55AA);
      chk($sformatf("stall%0d mem_wmask", i), 64'(mem_wmask), 64'h3);
      chk($sformatf("stall%0d mem_wen", i), 64'(mem_wen), 64'h1);
      chk($sformatf("stall%0d ifu_req_ready", i), 64'(ifu_req_ready), 64'h0);
      next_cyc();
    end
    mem_req_ready = 1;
    settle(); next_cyc();
    mem_req_ready = 0; mem_resp_valid = 1; mem_rdata = 32'hCAFE_F00D;
    settle();
    chk("wait ifu_req_ready", 64'(ifu_req_ready), 64'h0);
    next_cyc();
    mem_resp_valid = 0;
    settle();
    chk("stall lsu_resp_valid", 64'(lsu_resp_valid), 64'h1);
    chk("stall resp_rdata", 64'(resp_rdata), 64'hCAFE_F00D);
    chk("grant with response pulse", 64'(ifu_req_ready), 64'h1);
    next_cyc();
    ifu_req_valid = 0;
    drain();

    // Watchdog: memory never accepts
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000; lsu_wen = 0;
    mem_req_ready = 0; mem_resp_valid = 0;
    settle(); next_cyc();
    lsu_req_valid = 0;
    got = -1;
    for (int k = 1; k <= 15 && got < 0; k++) begin
      settle();
      if (k == 8) chk("timeout mem_req_valid before", 64'(mem_req_valid), 64'h1);
      if (lsu_resp_valid) begin
        got = k;
        chk("timeout resp_err", 64'(resp_err), 64'h1);
        chk("timeout resp_rdata", 64'(resp_rdata), 64'h0);
        chk("timeout mem_req_valid drop", 64'(mem_req_valid), 64'h0);
      end
      next_cyc();
    end
    chk("timeout latency from grant", 64'(got), 64'(TO + 1));
    mem_resp_valid = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stray ifu_resp_valid", 64'(ifu_resp_valid), 64'h0);
      chk("stray lsu_resp_valid", 64'(lsu_resp_valid), 64'h0);
      next_cyc();
    end
    mem_resp_valid = 0;

    // Randomized traffic with alternating fast/slow memory phases
    for (int i = 0; i < 3000; i++) begin
      bit slow;
      slow = ((i / 250) % 2) == 1;
      if (!ifu_req_valid || exp_ifu_acc) begin
        ifu_req_valid = ($urandom_range(0, 1) == 0);
        ifu_addr = $urandom;
      end
      if (!lsu_req_valid || exp_lsu_acc) begin
        lsu_req_valid = ($urandom_range(0, 1) == 0);
        lsu_addr = $urandom;
        lsu_wen = ($urandom_range(0, 1) == 0);
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom);
      end
      mem_req_ready  = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      mem_resp_valid = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      settle();
      next_cyc();
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Sits between those two masters and the memory/bus bridge.
- One transaction outstanding at a time.
- Round-robin arbitration on ties.
- A watchdog timeout returns an error response if memory never completes.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT, 255, maximum cycles from entering REQ to response; 0 disables; otherwise must be >=3.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU read address.
- ifu_resp_valid  out  1  one-cycle response pulse to IFU.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  DATA_W  write data.
- lsu_wmask  in  DATA_W/8  byte-enable mask.
- lsu_resp_valid  out  1  one-cycle response pulse to LSU.
- resp_rdata  out  DATA_W  response data, shared by both masters; qualified by the owner's resp_valid.
- resp_err  out  1  response is a timeout error; qualified by resp_valid.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  latched address.
- mem_wen  out  1  latched write enable.
- mem_wdata  out  DATA_W  latched write data.
- mem_wmask  out  DATA_W/8  latched mask.
- mem_resp_valid  in  1  memory completion; read data valid.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
Reset (rst low, asynchronous, any state):
- state = IDLE; owner = IFU; last_owner = LSU, so IFU wins the first tie.
- Watchdog counter = 0.
- All outputs 0, including the mem_* latches, resp_rdata and resp_err.
- An in-flight transaction is abandoned with no response.

States: IDLE, REQ, WAIT.

IDLE:
- If either req_valid is high, grant combinationally:
  - only one valid: that master wins;
  - both valid: the master that is not last_owner wins.
- Winner's req_ready = 1 for that single cycle. The loser's req_ready = 0 and its request must stay held.
- On grant, latch the request:
  - addr, wen, wdata, wmask;
  - for an IFU grant: wen = 0, wdata = 0, wmask = 0.
- Set owner and last_owner to the winner; clear the counter; go to REQ.

REQ:
- mem_req_valid = 1; mem_* fields stable until mem_req_ready.
- On mem_req_valid & mem_req_ready: go to WAIT.

WAIT:
- mem_req_valid = 0.
- mem_resp_valid is sampled only in WAIT.
- On mem_resp_valid: register mem_rdata into resp_rdata, set resp_err = 0, pulse the owner's resp_valid next cycle; go to IDLE.

Response and latency:
- resp_valid is high for exactly one cycle; masters must accept it that cycle.
- A new grant is allowed in the same cycle as the response pulse.
- Minimum latency: accept at C0, mem handshake at C1, mem_resp_valid at C2, resp_valid at C3.

Watchdog:
- Counter increments every cycle in REQ or WAIT.
- If TIMEOUT != 0 and TIMEOUT cycles elapse since entering REQ without completion:
  - owner's resp_valid = 1 in cycle (REQ entry + TIMEOUT), with resp_err = 1 and resp_rdata = 0;
  - mem_req_valid drops; go to IDLE.
- mem_resp_valid arriving in IDLE or REQ is ignored.

Invariants:
- At most one of ifu_req_ready / lsu_req_ready is high in any cycle.
- At most one resp_valid is high in any cycle.
- Never more than one transaction outstanding.

Test Plan:
1. IFU alone, addr 0x80000000; mem_req_ready = 1; mem_resp_valid at C2 with rdata 0x00100073 -> ifu_req_ready at C0; mem_req_valid at C1 with addr 0x80000000, wen 0, wmask 0; ifu_resp_valid at C3 with resp_rdata 0x00100073, resp_err 0; lsu_resp_valid stays 0.
2. Both masters held valid continuously from reset -> grants go IFU, LSU, IFU, LSU; each req_ready is a single-cycle pulse; never both high.
3. LSU write, addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF -> mem_wen 1 and matching mem_* fields; lsu_resp_valid pulses once; ifu_resp_valid stays 0.
4. mem_req_ready held 0 for 5 cycles, with ifu_req_valid raised meanwhile -> mem_req_valid and fields stable all 5 cycles; ifu_req_ready stays 0 until the arbiter returns to IDLE.
5. TIMEOUT = 8, mem_req_ready stuck at 0 -> lsu_resp_valid with resp_err 1 and resp_rdata 0 exactly 8 cycles after REQ entry; mem_req_valid drops; a stray mem_resp_valid afterwards produces no pulse.
6. rst driven low while in WAIT -> all outputs 0 immediately; after release, a tie grants IFU first and there is no response from the old transaction.
